// File: rtl/data_bus_ctrl_pkg.sv
// Shared widths, defaults, controller state encoding and write-buffer layout
// for the core data bus controller and its watchdog.
package data_bus_ctrl_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 8;

  localparam int                TIMEOUT_DEF  = 255;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDONE
  } state_t;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } wbuf_t;

endpackage

// File: rtl/data_bus_ctrl_if.sv
// Request/acknowledge data bus: master holds req and attributes until a one-cycle ack.
// rdata is only meaningful in the ack cycle of a read.
interface data_bus_ctrl_if;
  import data_bus_ctrl_pkg::*;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);

endinterface

// File: rtl/data_bus_ctrl_bus_watchdog.sv
// Counts bus request cycles without ack; timeout pulses combinationally in the TIMEOUT-th such cycle.
// Latency: pulse in the same cycle the limit is reached; no backpressure, counter clears on ack or idle.
module bus_watchdog
  import data_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of unacked request cycles already elapsed
  assign timeout = req & ~ack & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!req || ack || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Core-to-bus controller: stores are posted through a one-entry buffer, loads stall the core until data returns.
// Latency: load stalls 2 cycles plus bus wait; backpressure via core_run low while the buffer or bus is busy.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int                TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_in,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [BE_W-1:0]   core_be,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_run,
  output logic              err,
  data_bus_ctrl_if.master   bus
);

  state_t            state, state_nxt;
  wbuf_t             wbuf_q, wbuf_nxt;
  logic [DATA_W-1:0] hold_q, hold_nxt;
  logic              err_q;
  logic              stall, req, timeout, done, take_re, take_we;

  assign req     = (state == ST_WRITE) || (state == ST_READ);
  assign done    = req & (bus.ack | timeout);
  assign take_re = run_in & core_re;
  assign take_we = run_in & core_we & ~core_re;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .ack     (bus.ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      wbuf_q <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wbuf_q <= wbuf_nxt;
      hold_q <= hold_nxt;
      if (timeout) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wbuf_nxt  = wbuf_q;
    hold_nxt  = hold_q;
    stall     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall = core_re;
        if (take_re) begin
          wbuf_nxt.addr = core_addr;
          state_nxt     = ST_READ;
        end else if (take_we) begin
          wbuf_nxt  = '{be: core_be, addr: core_addr, wdata: core_wdata};
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A timed-out store completes exactly like an acked one, its data is dropped
        stall = core_re | core_we;
        if (done) begin
          if (take_re) begin
            wbuf_nxt.addr = core_addr;
            state_nxt     = ST_READ;
          end else if (take_we) begin
            wbuf_nxt = '{be: core_be, addr: core_addr, wdata: core_wdata};
            stall    = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        stall = 1'b1;
        if (done) begin
          hold_nxt  = bus.ack ? bus.rdata : ERR_DATA;
          state_nxt = ST_RDONE;
        end
      end
      ST_RDONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign core_run   = reset & run_in & ~stall;
  assign core_rdata = hold_q;
  assign err        = err_q;

  assign bus.req   = req;
  assign bus.we    = (state == ST_WRITE);
  assign bus.be    = (state == ST_WRITE) ? wbuf_q.be : '1;
  assign bus.addr  = wbuf_q.addr;
  assign bus.wdata = wbuf_q.wdata;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: directed bus scenarios plus random loads/stores against a memory model;
// a second instance with a short timeout covers abort and reset-during-read behaviour.
`timescale 1ns/1ps
module tb_data_bus_ctrl;
  import data_bus_ctrl_pkg::*;

  localparam int unsigned NOACK = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset, run_in, core_re, core_we, core_re2;
  logic [BE_W-1:0]   core_be;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata, core_rdata2;
  logic              core_run, core_run2, err, err2;

  data_bus_ctrl_if bus();
  data_bus_ctrl_if bus2();

  data_bus_ctrl dut (
    .clk(clk), .reset(reset), .run_in(run_in), .core_re(core_re), .core_we(core_we),
    .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_run(core_run), .err(err), .bus(bus)
  );

  data_bus_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .run_in(run_in), .core_re(core_re2), .core_we(1'b0),
    .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata2), .core_run(core_run2), .err(err2), .bus(bus2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  xact_t       bus_log[$];
  xact_t       exp_wr[$];
  int unsigned delay_q[$];
  int unsigned rand_max = 0;
  int unsigned cur_delay, seen;
  bit          active = 1'b0, stray_ack = 1'b0, rand_run = 1'b0;
  bit [31:0]   slv_mem[int];
  bit [31:0]   ref_mem[int];

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] be);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit [31:0] slv_rd(input int k);
    return slv_mem.exists(k) ? slv_mem[k] : 32'h0;
  endfunction

  function automatic bit [31:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  // Memory-backed bus slave for the main instance; each transaction waits cur_delay cycles before ack.
  always @(negedge clk) begin
    xact_t x;
    bus.ack = stray_ack;
    if (bus.req) begin
      if (!active) begin
        active    = 1'b1;
        seen      = 0;
        cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : $urandom_range(0, rand_max);
      end
      if (seen == cur_delay) begin
        bus.ack = 1'b1;
        active  = 1'b0;
        x = {bus.we, bus.addr, bus.be, bus.wdata};
        bus_log.push_back(x);
        if (bus.we) slv_mem[int'(bus.addr)] = merge(slv_rd(int'(bus.addr)), bus.wdata, bus.be);
        else        bus.rdata = slv_rd(int'(bus.addr));
      end else begin
        seen++;
      end
    end else begin
      active = 1'b0;
    end
  end

  always @(negedge clk) if (rand_run) run_in = ($urandom_range(0, 7) != 0);

  // Presents one access to the main instance and holds it until core_run accepts it.
  task automatic do_op(input bit is_load, input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                       input logic [DATA_W-1:0] wd, output int stalls, output logic [DATA_W-1:0] rd);
    int budget;
    budget = 400;
    stalls = 0;
    @(negedge clk);
    core_re = is_load; core_we = !is_load; core_addr = a; core_be = be; core_wdata = wd;
    #1;
    while (!core_run && budget > 0) begin
      if (run_in) stalls++;
      budget--;
      @(negedge clk); #1;
    end
    check_eq("accept", core_run, 1);
    rd = core_rdata;
    @(posedge clk); #1;
    core_re = 1'b0; core_we = 1'b0;
  endtask

  // Load on the short-timeout instance; its bus is acked after 'delay' wait cycles (NOACK = never).
  task automatic load2(input logic [ADDR_W-1:0] a, input int unsigned delay, input logic [DATA_W-1:0] d,
                       output int req_cyc, output logic [DATA_W-1:0] rd);
    int unsigned s;
    int budget;
    s = 0; budget = 50; req_cyc = 0;
    @(negedge clk);
    core_addr = a; core_re2 = 1'b1; bus2.ack = 1'b0;
    #1;
    while (!core_run2 && budget > 0) begin
      @(negedge clk);
      bus2.ack = 1'b0;
      if (bus2.req) begin
        req_cyc++;
        if (s == delay) begin bus2.ack = 1'b1; bus2.rdata = d; end
        s++;
      end
      #1;
      budget--;
    end
    check_eq("accept2", core_run2, 1);
    rd = core_rdata2;
    check_eq("req2_dropped", bus2.req, 0);
    @(posedge clk); #1;
    core_re2 = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    @(negedge clk);
    while (bus.req && budget > 0) begin @(negedge clk); budget--; end
    check_eq("drain", bus.req, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "hang");
  end

  initial begin
    int                stalls, lows, nw, rc;
    logic [DATA_W-1:0] rd, wd;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    bit                ld;

    reset = 1'b0; run_in = 1'b1; core_re = 1'b0; core_we = 1'b0; core_re2 = 1'b0;
    core_be = '0; core_addr = '0; core_wdata = '0;
    bus2.ack = 1'b0; bus2.rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", bus.req, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rdata", core_rdata, 0);
    check_eq("rst_run", core_run, 0);
    reset = 1'b1;

    // posted store, ack after 3 wait cycles: core never stalls
    bus_log.delete(); delay_q.push_back(3);
    do_op(1'b0, 30'h100, 4'hF, 32'h11223344, stalls, rd);
    check_eq("st_stalls", stalls, 0);
    lows = 0;
    repeat (6) begin @(negedge clk); #1; if (!core_run) lows++; end
    check_eq("st_run_low", lows, 0);
    drain();
    check_eq("st_count", bus_log.size(), 1);
    if (bus_log.size() == 1) begin
      check_eq("st_we", bus_log[0].we, 1);
      check_eq("st_addr", bus_log[0].addr, 30'h100);
      check_eq("st_be", bus_log[0].be, 4'hF);
      check_eq("st_data", bus_log[0].wdata, 32'h11223344);
    end

    // load with immediate ack: two stall cycles, data in the release cycle
    bus_log.delete(); delay_q.push_back(0); slv_mem[32'h40] = 32'hCAFEF00D;
    do_op(1'b1, 30'h40, 4'h0, 32'h0, stalls, rd);
    check_eq("ld_stalls", stalls, 2);
    check_eq("ld_data", rd, 32'hCAFEF00D);
    check_eq("ld_be", bus_log.size() > 0 ? bus_log[0].be : 4'h0, 4'hF);
    @(negedge clk);
    check_eq("ld_rdata_hold", core_rdata, 32'hCAFEF00D);

    // store then immediate load to the same word: load waits for the write (6 req cycles) plus one read cycle
    bus_log.delete(); delay_q.push_back(5); delay_q.push_back(0);
    do_op(1'b0, 30'h40, 4'hF, 32'h55667788, stalls, rd);
    check_eq("raw_st_stalls", stalls, 0);
    do_op(1'b1, 30'h40, 4'h0, 32'h0, stalls, rd);
    check_eq("raw_ld_stalls", stalls, 7);
    check_eq("raw_ld_data", rd, 32'h55667788);
    drain();
    check_eq("raw_count", bus_log.size(), 2);
    if (bus_log.size() == 2) begin
      check_eq("raw_first_we", bus_log[0].we, 1);
      check_eq("raw_second_we", bus_log[1].we, 0);
      check_eq("raw_second_addr", bus_log[1].addr, 30'h40);
    end

    // back-to-back stores, the second presented in the ack cycle of the first
    bus_log.delete(); delay_q.push_back(0); delay_q.push_back(0);
    do_op(1'b0, 30'h200, 4'b0011, 32'hA1A2A3A4, stalls, rd);
    check_eq("b2b_st1_stalls", stalls, 0);
    do_op(1'b0, 30'h201, 4'b1100, 32'hB1B2B3B4, stalls, rd);
    check_eq("b2b_st2_stalls", stalls, 0);
    drain();
    check_eq("b2b_count", bus_log.size(), 2);
    if (bus_log.size() == 2) begin
      check_eq("b2b_addr0", bus_log[0].addr, 30'h200);
      check_eq("b2b_addr1", bus_log[1].addr, 30'h201);
      check_eq("b2b_be1", bus_log[1].be, 4'b1100);
      check_eq("b2b_data1", bus_log[1].wdata, 32'hB1B2B3B4);
    end

    // random traffic over a few words with random bus waits and run_in gaps
    bus_log.delete(); exp_wr.delete(); rand_max = 6; rand_run = 1'b1;
    for (int n = 0; n < 200; n++) begin
      ld = ($urandom_range(0, 1) == 0);
      a  = ADDR_W'($urandom_range(0, 7));
      be = BE_W'($urandom_range(1, 15));
      wd = $urandom;
      do_op(ld, a, be, wd, stalls, rd);
      if (ld) begin
        check_eq("rand_load", rd, ref_rd(int'(a)));
      end else begin
        ref_mem[int'(a)] = merge(ref_rd(int'(a)), wd, be);
        exp_wr.push_back({1'b1, a, be, wd});
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_run = 1'b0; run_in = 1'b1;
    drain();
    nw = 0;
    foreach (bus_log[i]) begin
      if (bus_log[i].we) begin
        if (nw < exp_wr.size()) begin
          check_eq("rand_wr_addr", bus_log[i].addr, exp_wr[nw].addr);
          check_eq("rand_wr_be", bus_log[i].be, exp_wr[nw].be);
          check_eq("rand_wr_data", bus_log[i].wdata, exp_wr[nw].wdata);
        end
        nw++;
      end
    end
    check_eq("rand_wr_count", nw, exp_wr.size());
    check_eq("rand_err", err, 0);

    // short-timeout instance: ack in the last allowed cycle, then no ack at all
    load2(30'h10, 3, 32'h13579BDF, rc, rd);
    check_eq("to_edge_reqcyc", rc, 4);
    check_eq("to_edge_data", rd, 32'h13579BDF);
    check_eq("to_edge_err", err2, 0);
    load2(30'h11, NOACK, 32'h0, rc, rd);
    check_eq("to_reqcyc", rc, 4);
    check_eq("to_data", rd, 32'hDEADBEEF);
    check_eq("to_err", err2, 1);

    // reset in the middle of a read, then a stray ack
    @(negedge clk);
    core_addr = 30'h22; core_re2 = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rr_req_before", bus2.req, 1);
    reset = 1'b0;
    #1;
    check_eq("rr_run_in_reset", core_run2, 0);
    @(negedge clk);
    check_eq("rr_req", bus2.req, 0);
    check_eq("rr_err", err2, 0);
    check_eq("rr_rdata", core_rdata2, 0);
    check_eq("rr_main_run", core_run, 0);
    reset = 1'b1; core_re2 = 1'b0; bus2.rdata = 32'h0BADF00D; bus2.ack = 1'b1;
    @(negedge clk);
    bus2.ack = 1'b0;
    #1;
    check_eq("rr_stray_req", bus2.req, 0);
    check_eq("rr_stray_rdata", core_rdata2, 0);
    check_eq("rr_stray_run", core_run2, 1);
    check_eq("rr_stray_err", err2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
